// File: rtl/controle_irrigacao_if.sv
// Sensor inputs and controller outputs of the irrigation controller.
// master drives the raw probes; slave is the controller.
interface controle_irrigacao_if;
  logic       highLevel;
  logic       mediumLevel;
  logic       lowLevel;
  logic       temperatura;
  logic       umidadeSolo;
  logic       umidadeAr;
  logic       alarme;
  logic       erro;
  logic       valvulaEntrada;
  logic       gotejamento;
  logic       aspersao;
  logic [2:0] estado;

  modport master (
    output highLevel, mediumLevel, lowLevel, temperatura, umidadeSolo, umidadeAr,
    input  alarme, erro, valvulaEntrada, gotejamento, aspersao, estado
  );

  modport slave (
    input  highLevel, mediumLevel, lowLevel, temperatura, umidadeSolo, umidadeAr,
    output alarme, erro, valvulaEntrada, gotejamento, aspersao, estado
  );
endinterface

// File: rtl/controle_irrigacao.sv
// Irrigation controller: synchronized/debounced probes, timed drip/spray FSM, hysteretic inlet valve.
// Input-to-output latency DEBOUNCE_CYCLES+3 edges; no backpressure, all outputs registered or state-decoded.
module controle_irrigacao #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_RUN         = 8,
  parameter int MAX_RUN         = 64,
  parameter int COOLDOWN        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  controle_irrigacao_if.slave   irr_io
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIP  = 3'd1,
    ST_SPRAY = 3'd2,
    ST_COOL  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [7:0]  DEB_LIM  = 8'(DEBOUNCE_CYCLES);
  localparam logic [15:0] MIN_LIM  = 16'(MIN_RUN - 1);
  localparam logic [15:0] MAX_LIM  = 16'(MAX_RUN - 1);
  localparam logic [15:0] COOL_LIM = 16'(COOLDOWN - 1);

  // Bit order {H, M, L, T, S, A}
  logic [5:0] raw;
  logic [5:0] sync1_q, sync2_q;
  logic [5:0] deb_q, deb_d;
  logic [7:0] dbc_q [6];
  logic [7:0] dbc_d [6];

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        alarme_q, erro_q, valvula_q, valvula_d;

  logic h, m, l, t, s, a;
  logic err, alm, req_drip, req_spray;

  assign raw = {irr_io.highLevel, irr_io.mediumLevel, irr_io.lowLevel,
                irr_io.temperatura, irr_io.umidadeSolo, irr_io.umidadeAr};

  // Counter only advances while the synchronized value disagrees with the accepted one.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 6; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dbc_q[i] + 8'd1 == DEB_LIM) begin
          deb_d[i] = sync2_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + 8'd1;
        end
      end
    end
  end

  assign {h, m, l, t, s, a} = deb_q;

  assign err       = (h & ~m) | (m & ~l);
  assign alm       = err | ~l;
  assign req_drip  = ~s & a & (t | ~m);
  assign req_spray = ~s & ((~t & m) | ~a);

  always_comb begin
    valvula_d = valvula_q;
    if (err) begin
      valvula_d = 1'b0;
    end else if (!m) begin
      valvula_d = 1'b1;
    end else if (h) begin
      valvula_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (alm)            state_d = ST_FAULT;
        else if (req_drip)  state_d = ST_DRIP;
        else if (req_spray) state_d = ST_SPRAY;
      end
      ST_DRIP: begin
        if (alm)                                state_d = ST_FAULT;
        else if (cnt_q >= MAX_LIM)              state_d = ST_COOL;
        else if (cnt_q >= MIN_LIM && !req_drip) state_d = ST_COOL;
      end
      ST_SPRAY: begin
        if (alm)                                 state_d = ST_FAULT;
        else if (cnt_q >= MAX_LIM)               state_d = ST_COOL;
        else if (cnt_q >= MIN_LIM && !req_spray) state_d = ST_COOL;
      end
      ST_COOL: begin
        if (alm)                    state_d = ST_FAULT;
        else if (cnt_q >= COOL_LIM) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (!alm) state_d = ST_COOL;
      end
      default: state_d = ST_FAULT;
    endcase
  end

  // Run counter restarts on every state entry and saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      for (int i = 0; i < 6; i++) dbc_q[i] <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      alarme_q  <= 1'b0;
      erro_q    <= 1'b0;
      valvula_q <= 1'b0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      for (int i = 0; i < 6; i++) dbc_q[i] <= dbc_d[i];
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alarme_q  <= alm;
      erro_q    <= err;
      valvula_q <= valvula_d;
    end
  end

  assign irr_io.alarme         = alarme_q;
  assign irr_io.erro           = erro_q;
  assign irr_io.valvulaEntrada = valvula_q;
  assign irr_io.gotejamento    = (state_q == ST_DRIP);
  assign irr_io.aspersao       = (state_q == ST_SPRAY);
  assign irr_io.estado         = state_q;

endmodule

// File: tb/tb_controle_irrigacao.sv
// Directed bench for controle_irrigacao: inputs driven and outputs sampled on the falling edge.
module tb_controle_irrigacao;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  controle_irrigacao_if irr ();

  controle_irrigacao #(
    .DEBOUNCE_CYCLES(4),
    .MIN_RUN(8),
    .MAX_RUN(64),
    .COOLDOWN(16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .irr_io (irr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_state(input logic [2:0] st, input int max_cyc, output int n, output bit hit);
    n   = 0;
    hit = 1'b0;
    while (!hit && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (irr.estado === st) hit = 1'b1;
    end
  endtask

  task automatic count_state(input logic [2:0] st, inout int len);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
      if (irr.estado === st) len++;
      else done = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    irr.highLevel = 1'b1; irr.mediumLevel = 1'b1; irr.lowLevel = 1'b1;
    irr.temperatura = 1'b0; irr.umidadeSolo = 1'b1; irr.umidadeAr = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({irr.alarme, irr.erro, irr.valvulaEntrada, irr.gotejamento, irr.aspersao, irr.estado} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000000",
               {irr.alarme, irr.erro, irr.valvulaEntrada, irr.gotejamento, irr.aspersao, irr.estado});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (irr.alarme !== 1'b1 || irr.estado !== 3'd4 || irr.valvulaEntrada !== 1'b1) begin
      bad++;
      $display("FAIL reset_edge1 alarme=%b estado=%0d valvula=%b want 1/4/1", irr.alarme, irr.estado, irr.valvulaEntrada);
    end
    repeat (5) @(negedge clk);
    total++;
    if (irr.alarme !== 1'b1 || irr.estado !== 3'd4) begin
      bad++;
      $display("FAIL reset_edge6 alarme=%b estado=%0d want 1/4", irr.alarme, irr.estado);
    end
    @(negedge clk);
    total++;
    if (irr.alarme !== 1'b0 || irr.estado !== 3'd3 || irr.valvulaEntrada !== 1'b0) begin
      bad++;
      $display("FAIL reset_edge7 alarme=%b estado=%0d valvula=%b want 0/3/0", irr.alarme, irr.estado, irr.valvulaEntrada);
    end
    repeat (15) @(negedge clk);
    total++;
    if (irr.estado !== 3'd3) begin
      bad++;
      $display("FAIL reset_cool_end estado=%0d want 3", irr.estado);
    end
    @(negedge clk);
    total++;
    if (irr.estado !== 3'd0) begin
      bad++;
      $display("FAIL reset_idle estado=%0d want 0", irr.estado);
    end
  endtask

  task automatic test_drip_run;
    int n, len;
    bit hit;
    irr.umidadeSolo = 1'b0; irr.umidadeAr = 1'b1; irr.temperatura = 1'b1;
    wait_state(3'd1, 20, n, hit);
    total++;
    if (!hit || n != 7) begin
      bad++;
      $display("FAIL drip_latency hit=%b edges=%0d want 1/7", hit, n);
    end
    total++;
    if (irr.gotejamento !== 1'b1 || irr.aspersao !== 1'b0) begin
      bad++;
      $display("FAIL drip_outputs got=%b%b want 10", irr.gotejamento, irr.aspersao);
    end
    @(negedge clk);
    irr.umidadeSolo = 1'b1;
    len = 2;
    count_state(3'd1, len);
    total++;
    if (len != 8 || irr.estado !== 3'd3 || irr.gotejamento !== 1'b0) begin
      bad++;
      $display("FAIL drip_min_run len=%0d estado=%0d got=%b want 8/3/0", len, irr.estado, irr.gotejamento);
    end
    len = 1;
    count_state(3'd3, len);
    total++;
    if (len != 16 || irr.estado !== 3'd0) begin
      bad++;
      $display("FAIL drip_cooldown len=%0d estado=%0d want 16/0", len, irr.estado);
    end
  endtask

  task automatic test_spray_cap;
    int n, len;
    bit hit;
    irr.umidadeSolo = 1'b0; irr.umidadeAr = 1'b0;
    wait_state(3'd2, 20, n, hit);
    total++;
    if (!hit || irr.aspersao !== 1'b1) begin
      bad++;
      $display("FAIL spray_start hit=%b asp=%b want 1/1", hit, irr.aspersao);
    end
    len = 1;
    count_state(3'd2, len);
    total++;
    if (len != 64 || irr.estado !== 3'd3 || irr.aspersao !== 1'b0) begin
      bad++;
      $display("FAIL spray_max_run len=%0d estado=%0d asp=%b want 64/3/0", len, irr.estado, irr.aspersao);
    end
    len = 1;
    count_state(3'd3, len);
    total++;
    if (len != 16 || irr.estado !== 3'd0) begin
      bad++;
      $display("FAIL spray_cooldown len=%0d estado=%0d want 16/0", len, irr.estado);
    end
    @(negedge clk);
    total++;
    if (irr.estado !== 3'd2) begin
      bad++;
      $display("FAIL spray_reenter estado=%0d want 2", irr.estado);
    end
  endtask

  task automatic test_fault_during_run;
    int n;
    bit hit;
    bit early;
    irr.umidadeAr = 1'b1;
    wait_state(3'd1, 100, n, hit);
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL fault_drip_start estado=%0d want 1", irr.estado);
    end
    irr.mediumLevel = 1'b0;
    early = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (irr.estado !== 3'd1 || irr.erro !== 1'b0) early = 1'b1;
    end
    total++;
    if (early) begin
      bad++;
      $display("FAIL fault_early reacted before edge 7 estado=%0d erro=%b", irr.estado, irr.erro);
    end
    @(negedge clk);
    total++;
    if (irr.erro !== 1'b1 || irr.alarme !== 1'b1 || irr.estado !== 3'd4 ||
        irr.gotejamento !== 1'b0 || irr.valvulaEntrada !== 1'b0) begin
      bad++;
      $display("FAIL fault_edge7 erro=%b alarme=%b estado=%0d got=%b valv=%b want 1/1/4/0/0",
               irr.erro, irr.alarme, irr.estado, irr.gotejamento, irr.valvulaEntrada);
    end
    irr.mediumLevel = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (irr.estado !== 3'd4) begin
      bad++;
      $display("FAIL fault_hold estado=%0d want 4", irr.estado);
    end
    @(negedge clk);
    total++;
    if (irr.estado !== 3'd3 || irr.alarme !== 1'b0 || irr.erro !== 1'b0) begin
      bad++;
      $display("FAIL fault_clear estado=%0d alarme=%b erro=%b want 3/0/0", irr.estado, irr.alarme, irr.erro);
    end
  endtask

  task automatic test_valve_hysteresis;
    irr.highLevel = 1'b0; irr.mediumLevel = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (irr.valvulaEntrada !== 1'b0) begin
      bad++;
      $display("FAIL valve_before_low got=%b want 0", irr.valvulaEntrada);
    end
    @(negedge clk);
    total++;
    if (irr.valvulaEntrada !== 1'b1 || irr.alarme !== 1'b0) begin
      bad++;
      $display("FAIL valve_low valv=%b alarme=%b want 1/0", irr.valvulaEntrada, irr.alarme);
    end
    irr.mediumLevel = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (irr.valvulaEntrada !== 1'b1) begin
      bad++;
      $display("FAIL valve_mid_rising got=%b want 1", irr.valvulaEntrada);
    end
    irr.highLevel = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (irr.valvulaEntrada !== 1'b1) begin
      bad++;
      $display("FAIL valve_before_high got=%b want 1", irr.valvulaEntrada);
    end
    @(negedge clk);
    total++;
    if (irr.valvulaEntrada !== 1'b0) begin
      bad++;
      $display("FAIL valve_high got=%b want 0", irr.valvulaEntrada);
    end
    irr.highLevel = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (irr.valvulaEntrada !== 1'b0) begin
      bad++;
      $display("FAIL valve_mid_falling got=%b want 0", irr.valvulaEntrada);
    end
  endtask

  task automatic test_debounce;
    int n;
    bit hit;
    bit moved;
    irr.umidadeSolo = 1'b1;
    wait_state(3'd0, 200, n, hit);
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL deb_settle estado=%0d want 0", irr.estado);
    end
    repeat (3) @(negedge clk);
    irr.umidadeSolo = 1'b0;
    repeat (3) @(negedge clk);
    irr.umidadeSolo = 1'b1;
    moved = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (irr.estado !== 3'd0 || irr.gotejamento !== 1'b0 || irr.alarme !== 1'b0 ||
          irr.erro !== 1'b0 || irr.valvulaEntrada !== 1'b0) moved = 1'b1;
    end
    total++;
    if (moved) begin
      bad++;
      $display("FAIL deb_glitch3 outputs changed estado=%0d", irr.estado);
    end
    irr.umidadeSolo = 1'b0;
    repeat (4) @(negedge clk);
    irr.umidadeSolo = 1'b1;
    wait_state(3'd1, 10, n, hit);
    total++;
    if (!hit || n != 3) begin
      bad++;
      $display("FAIL deb_pulse4 hit=%b edges=%0d want 1/3", hit, n);
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({irr.alarme, irr.erro, irr.valvulaEntrada, irr.gotejamento, irr.aspersao, irr.estado} !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_run got=%b want 00000000",
               {irr.alarme, irr.erro, irr.valvulaEntrada, irr.gotejamento, irr.aspersao, irr.estado});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_drip_run();
    test_spray_cap();
    test_fault_during_run();
    test_valve_hysteresis();
    test_debounce();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
